// File: rtl/sub_bytes_pkg.sv
// Shared sizing constants and FSM encoding for the sequential SubBytes engine.
// Optional abort support in sub_bytes_seq is selected with SUBBYTES_ABORT_EN.
package sub_bytes_pkg;

    localparam int NUM_BYTES = 16;
    localparam int SBOX_LAT  = 1;
    localparam int IDX_W     = 4;

    typedef logic [IDX_W-1:0] idx_t;

    // Element NUM_BYTES-1 is the top lane, i.e. AES byte 0.
    typedef logic [NUM_BYTES-1:0][7:0] state_bytes_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fsm_state_t;

endpackage

// File: rtl/sub_bytes_sbox.sv
// Registered, enable-gated AES S-box LUT; shared between SubBytes and key expansion.
module sub_bytes_sbox (
    input  logic       clk,
    input  logic       en,
    input  logic [7:0] sel,
    output logic [7:0] data
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_ff @(posedge clk) begin
        if (en) begin
            data <= SBOX[sel];
        end
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Byte-serial AES SubBytes driving an external registered S-box LUT, 18 cycles per state.
// Defining SUBBYTES_ABORT_EN adds an abort input that cancels a run in RUN or DRAIN.
module sub_bytes_seq
    import sub_bytes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] state_in,
`ifdef SUBBYTES_ABORT_EN
    input  logic         abort,
`endif
    output logic [7:0]   sbox_sel,
    output logic         sbox_en,
    input  logic [7:0]   sbox_data,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out
);

    fsm_state_t   state;
    fsm_state_t   next_state;
    idx_t         issue_idx;
    idx_t         write_idx;
    idx_t         issue_lane;
    idx_t         write_lane;
    state_bytes_t captured;
    state_bytes_t result;
    logic         accept;
    logic         last_issue;
    logic         abort_req;
    logic         collect;

    assign accept     = (state == IDLE) && start;
    assign last_issue = (issue_idx == idx_t'(NUM_BYTES - 1));

`ifdef SUBBYTES_ABORT_EN
    assign abort_req = abort && ((state == RUN) || (state == DRAIN));
`else
    assign abort_req = 1'b0;
`endif

    // LUT data lags the issue by SBOX_LAT cycles, so collection starts once that many bytes are in flight.
    assign collect = !abort_req &&
                     (((state == RUN) && (issue_idx >= idx_t'(SBOX_LAT))) || (state == DRAIN));

    // Byte 0 lives in the top lane, so a byte index maps to its lane by bitwise complement.
    assign issue_lane = ~issue_idx;
    assign write_lane = ~write_idx;

    assign sbox_sel  = captured[issue_lane];
    assign sbox_en   = (state == RUN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_out = result;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_issue) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort_req) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_idx <= '0;
            write_idx <= '0;
            captured  <= '0;
            result    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                captured  <= state_in;
                issue_idx <= '0;
                write_idx <= '0;
            end else if (abort_req) begin
                issue_idx <= '0;
                write_idx <= '0;
            end else begin
                if (state == RUN) begin
                    issue_idx <= issue_idx + idx_t'(1);
                end
                if (collect) begin
                    result[write_lane] <= sbox_data;
                    write_idx          <= write_idx + idx_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq with the real S-box LUT and a GF(2^8) reference model.
// Abort scenarios are exercised when SUBBYTES_ABORT_EN is defined.
module tb_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] state_in = '0;
    logic         abort_in = 1'b0;
    logic [7:0]   sbox_sel;
    logic         sbox_en;
    logic [7:0]   sbox_data;
    logic         busy;
    logic         done;
    logic [127:0] state_out;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;
    int dones_seen = 0;

    // Model: age counts edges since acceptance (0 = idle, 18 = done cycle).
    int           age = 0;
    logic [127:0] cap = '0;
    logic [127:0] exp_out = '0;
    logic         out_known = 1'b0;

    sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state_in  (state_in),
`ifdef SUBBYTES_ABORT_EN
        .abort     (abort_in),
`endif
        .sbox_sel  (sbox_sel),
        .sbox_en   (sbox_en),
        .sbox_data (sbox_data),
        .busy      (busy),
        .done      (done),
        .state_out (state_out)
    );

    sub_bytes_sbox lut (
        .clk  (clk),
        .en   (sbox_en),
        .sel  (sbox_sel),
        .data (sbox_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Multiplicative inverse as x^254, followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_model(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_model(s[127-8*i -: 8]);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic [127:0] d, input logic r, input logic a);
        @(negedge clk);
        start    = s;
        state_in = d;
        rst      = r;
        abort_in = a;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst) begin
            age       <= 0;
            exp_out   <= '0;
            out_known <= 1'b1;
        end else if (age == 0) begin
            if (start) begin
                age <= 1;
                cap <= state_in;
            end
        end else if (abort_in && age <= 17) begin
            age       <= 0;
            out_known <= 1'b0;
        end else if (age == 18) begin
            age <= 0;
        end else begin
            age <= age + 1;
            if (age == 17) begin
                exp_out   <= sub_model(cap);
                out_known <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check_output("ctrl_busy_done_en", {125'd0, busy, done, sbox_en},
                     {125'd0, age != 0, age == 18, (age >= 1) && (age <= 16)});
        if (age >= 1 && age <= 16) begin
            check_output("sbox_sel", {120'd0, sbox_sel}, {120'd0, cap[127-8*(age-1) -: 8]});
        end
        if (out_known && (age == 0 || age == 18)) begin
            check_output("state_out", state_out, exp_out);
        end
        if (done) dones_seen++;
    end

    // Called right after the accepting negedge has been driven; returns at the done cycle or on timeout.
    task automatic wait_done(input string name, input logic [127:0] expected);
        int lat = 1;
        apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
        while (!done && lat < 40) begin
            apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
            lat++;
        end
        check_output({name, "_latency"}, 128'(lat), 128'd18);
        check_output({name, "_result"}, state_out, expected);
        apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
        check_output({name, "_done_width"}, {127'd0, done}, 128'd0);
    endtask

    task automatic run_vector(input string name, input logic [127:0] val, input logic [127:0] expected);
        apply_stimulus(1'b1, val, 1'b0, 1'b0);
        wait_done(name, expected);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        logic [127:0] v;

        check_output("model_sbox_00", {120'd0, sbox_model(8'h00)}, {120'd0, 8'h63});
        check_output("model_sbox_53", {120'd0, sbox_model(8'h53)}, {120'd0, 8'hed});
        check_output("model_fips", sub_model(128'h193de3bea0f4e22b9ac68d2ae9f84808),
                     128'hd42711aee0bf98f1b8b45de51e415230);

        // Reset with start held high: start must be ignored.
        apply_stimulus(1'b1, rand128(), 1'b1, 1'b0);
        apply_stimulus(1'b1, rand128(), 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("reset_busy", {127'd0, busy}, 128'd0);
        check_output("reset_state_out", state_out, 128'd0);

        run_vector("zero", 128'h0, 128'h63636363636363636363636363636363);
        run_vector("fips", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);

        // Stray starts while busy and in the done cycle, then a back-to-back accept.
        v = rand128();
        apply_stimulus(1'b1, v, 1'b0, 1'b0);
        cnt = 0;
        for (int k = 1; k <= 18; k++) begin
            apply_stimulus((k == 5) || (k == 17) || (k == 18), rand128(), 1'b0, 1'b0);
            if (done) cnt++;
        end
        check_output("ignored_starts_done_count", 128'(cnt), 128'd1);
        check_output("ignored_starts_result", state_out, sub_model(v));
        v = rand128();
        apply_stimulus(1'b1, v, 1'b0, 1'b0);
        wait_done("reaccept", sub_model(v));

        // Reset in the middle of RUN.
        apply_stimulus(1'b1, rand128(), 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
        apply_stimulus(1'b0, rand128(), 1'b1, 1'b0);
        apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
        check_output("midrst_ctrl", {125'd0, busy, done, sbox_en}, 128'd0);
        check_output("midrst_state_out", state_out, 128'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
            if (done) cnt++;
        end
        check_output("midrst_no_done", 128'(cnt), 128'd0);

`ifdef SUBBYTES_ABORT_EN
        apply_stimulus(1'b1, rand128(), 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
        apply_stimulus(1'b0, rand128(), 1'b0, 1'b1);
        apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
        check_output("abort_busy", {127'd0, busy}, 128'd0);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
            if (done) cnt++;
        end
        check_output("abort_no_done", 128'(cnt), 128'd0);
        run_vector("after_abort", 128'h000102030405060708090a0b0c0d0e0f,
                   128'h637c777bf26b6fc53001672bfed7ab76);
`endif

        // Randomised traffic, checked cycle by cycle against the model.
        cnt = dones_seen;
        for (int k = 0; k < 800; k++) begin
`ifdef SUBBYTES_ABORT_EN
            apply_stimulus($urandom_range(0, 3) == 0, rand128(), $urandom_range(0, 149) == 0,
                           $urandom_range(0, 59) == 0);
`else
            apply_stimulus($urandom_range(0, 3) == 0, rand128(), $urandom_range(0, 149) == 0, 1'b0);
`endif
        end
        apply_stimulus(1'b0, rand128(), 1'b0, 1'b0);
        check_output("random_progress", {127'd0, dones_seen > cnt + 10}, 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 SHALL have no parameters; all sizing constants come from the shared package (REQ-030).
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to run SubBytes on state_in; honoured only in IDLE.
REQ-005 state_in  input  128  AES state; byte 0 = bits [127:120], byte 15 = bits [7:0].
REQ-006 sbox_sel  output  8  S-box LUT address; combinational mux of the captured state byte at the issue index.
REQ-007 sbox_en  output  1  S-box LUT enable; high only in RUN.
REQ-008 sbox_data  input  8  S-box LUT result, registered inside the LUT one edge after sel/en are sampled.
REQ-009 busy  output  1  high from the accepting edge until done deasserts.
REQ-010 done  output  1  one-cycle pulse; state_out is valid in that cycle and holds until the next accepted start.
REQ-011 state_out  output  128  substituted state, same byte order as state_in.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE: start=1 -> capture state_in into an internal register, issue index=0, write index=0, go to RUN.
REQ-014 RUN: each cycle drive sbox_sel = captured byte[issue index] with sbox_en=1; issue index increments; after index 15 is issued, go to DRAIN.
REQ-015 Collect: from the second RUN cycle through DRAIN, each edge writes sbox_data into state_out byte[write index]; write index then increments.
REQ-016 DRAIN: writes byte 15, then goes to DONE; sbox_en=0.
REQ-017 DONE: done=1 for exactly one cycle, then IDLE.
REQ-018 Latency SHALL be fixed: with start accepted at edge E0, done is high in the cycle after edge E17, giving 18 cycles from acceptance to the done cycle.
REQ-019 start while busy SHALL be ignored, with no queuing and no change to the captured state.
REQ-020 start during the DONE cycle SHALL be ignored; the earliest re-accept is the following IDLE cycle.
REQ-021 Index counters SHALL be 4-bit, wrap 15->0 only on the transition out of RUN or DRAIN, and never advance in IDLE or DONE.
REQ-022 state_in changes after the accepting edge SHALL NOT affect the result.
REQ-023 state_out SHALL be updated byte-wise during collection; consumers use it only when done=1.

Reset
REQ-024 RST=1 at any edge SHALL force IDLE, even mid-operation, and discard the in-flight operation.
REQ-025 Reset values: busy=0, done=0, sbox_en=0, state_out=0, indices=0, captured state=0.
REQ-026 start asserted together with RST SHALL be ignored.

Configuration
REQ-027 Macro SUBBYTES_ABORT_EN defined: adds input port abort (1 bit).
REQ-028 With SUBBYTES_ABORT_EN, abort=1 in RUN or DRAIN -> IDLE at the next edge, with no done pulse, busy=0, and state_out keeping any partially written bytes. abort SHALL have no effect in IDLE or DONE, and RST SHALL have priority over abort.
REQ-029 Macro SUBBYTES_ABORT_EN undefined: no abort port, and behaviour exactly as REQ-012..REQ-026.

Structure
REQ-030 Shared package sub_bytes_pkg SHALL hold the FSM state enum typedef, NUM_BYTES=16, SBOX_LAT=1 and the byte-index width (4).
REQ-031 No sub-module SHALL be instantiated inside; the S-box LUT stays external, so one LUT can be shared with the key-expansion path.
REQ-032 Top-level integration SHALL wire sbox_sel/sbox_en/sbox_data to the team's registered, enable-gated S-box LUT, sharing the same CLK.

Verification
REQ-033 Bench SHALL instantiate sub_bytes_seq with the real S-box LUT and a cycle counter, and check the following.
REQ-034 state_in=0x00000000000000000000000000000000, start -> done 18 cycles after accept, state_out=0x63636363636363636363636363636363.
REQ-035 FIPS-197 vector state_in=0x193de3bea0f4e22b9ac68d2ae9f84808 -> state_out=0xd42711aee0bf98f1b8b45de51e415230, done pulse exactly one cycle wide.
REQ-036 start pulsed again at cycles 5 and 17 after accept -> both ignored; single done; a new start in the IDLE cycle after done is accepted.
REQ-037 RST at cycle 8 of RUN -> next cycle busy=0, done=0, sbox_en=0, state_out=0; no done pulse for 30 cycles.
REQ-038 SUBBYTES_ABORT_EN: abort at cycle 10 -> IDLE next edge, no done; then state_in=0x000102030405060708090a0b0c0d0e0f -> state_out=0x637c777bf26b6fc53001672bfed7ab76.
